// File: rtl/acc_ram_arb_if.sv
// rtl/acc_ram_arb_if.sv - port bundle for the accumulator result RAM arbiter
// slave = arbiter side, master = write-back stage / APB / RAM side.
interface acc_ram_arb_if #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              ram_en;
  logic              ram_we_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_req, rd_addr, ram_rdata,
    output wb_ready, rd_ready, rd_data, ram_en, ram_we_n, ram_addr, ram_wdata, fifo_level
  );

  modport master (
    output wb_valid, wb_addr, wb_data, rd_req, rd_addr, ram_rdata,
    input  wb_ready, rd_ready, rd_data, ram_en, ram_we_n, ram_addr, ram_wdata, fifo_level
  );
endinterface

// File: rtl/acc_ram_arb.sv
// rtl/acc_ram_arb.sv - single-port accumulator RAM arbiter: buffered write-backs vs APB reads
// Grants are decoded from registered state so a read issues in the first cycle of rd_req.
module acc_ram_arb #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_WB_WAIT = 8
) (
  input logic          clk,
  input logic          rst,
  acc_ram_arb_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int STV_W = $clog2(MAX_WB_WAIT + 1);

  typedef enum logic {IDLE, RD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [LVL_W-1:0]  level;
  logic [STV_W-1:0]  starve_cnt;
  logic [DATA_W-1:0] rd_data_q;
  logic [PTR_W-1:0]  slot_off;
  logic              full;
  logic              empty;
  logic              hazard;
  logic              push;
  logic              wr_grant;
  logic              rd_grant;

  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign push  = bus.wb_valid && !full;

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    hazard   = 1'b0;
    slot_off = '0;
    for (int s = 0; s < FIFO_DEPTH; s++) begin
      slot_off = PTR_W'(s) - head;
      if (({1'b0, slot_off} < level) && (q_addr[s] == bus.rd_addr))
        hazard = 1'b1;
    end
    hazard = hazard && bus.rd_req;
  end

  assign wr_grant = !rst && (state == IDLE) && !empty &&
                    (full || (starve_cnt >= STV_W'(MAX_WB_WAIT)) || hazard || !bus.rd_req);
  assign rd_grant = !rst && (state == IDLE) && !wr_grant && bus.rd_req;

  assign bus.wb_ready   = !full;
  assign bus.fifo_level = level;
  assign bus.ram_en     = wr_grant || rd_grant;
  assign bus.ram_we_n   = !wr_grant;
  assign bus.ram_addr   = wr_grant ? q_addr[head] : (rd_grant ? bus.rd_addr : '0);
  assign bus.ram_wdata  = wr_grant ? q_data[head] : '0;
  assign bus.rd_ready   = (state == RD);
  assign bus.rd_data    = (state == RD) ? bus.ram_rdata : rd_data_q;

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= bus.wb_addr;
      q_data[tail] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      level      <= '0;
      starve_cnt <= '0;
      rd_data_q  <= '0;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (wr_grant)
        head <= head + PTR_W'(1);
      case ({push, wr_grant})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (wr_grant || empty)
        starve_cnt <= '0;
      else if (starve_cnt < STV_W'(MAX_WB_WAIT))
        starve_cnt <= starve_cnt + STV_W'(1);
      case (state)
        IDLE: if (rd_grant) state <= RD;
        RD: begin
          rd_data_q <= bus.ram_rdata;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_ram_arb.sv
// tb/tb_acc_ram_arb.sv - directed vector bench for acc_ram_arb with a behavioural RAM
module tb_acc_ram_arb;
  localparam int ADDR_W = 8, DATA_W = 32, FIFO_DEPTH = 4, MAX_WB_WAIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_ram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  acc_ram_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_WB_WAIT(MAX_WB_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    bit          is_rd;
    logic [7:0]  addr;
    logic [31:0] data;
  } vec_t;

  logic [31:0] mem [256];
  wr_t         wlog[$];
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) begin
    if (bus.ram_en && !bus.ram_we_n) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      wlog.push_back({bus.ram_addr, bus.ram_wdata});
    end
    if (bus.ram_en && bus.ram_we_n)
      bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, got no event expected one", name);
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    bit ok = 0;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.wb_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("push");
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input bit keep,
                    output logic [31:0] data, output int lat, output int lvl);
    bit ok = 0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    lat  = 0;
    lvl  = 0;
    data = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rd_ready) begin
        data = bus.rd_data;
        lvl  = int'(bus.fifo_level);
        ok   = 1;
        break;
      end
    end
    if (!ok) timeout("rd");
    @(posedge clk); #1;
    if (!keep) bus.rd_req = 1'b0;
  endtask

  task automatic wait_rd_ready();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_rd_ready");
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok = 0;
    bus.rd_req   = 1'b0;
    bus.wb_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.fifo_level == 0 && !bus.ram_en) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("drain");
    @(posedge clk); #1;
  endtask

  vec_t        tbl [12];
  logic [31:0] d;
  int          lat;
  int          lvl;
  int          maxlvl;
  int          forced;
  int          cyc;
  bit          saw_full;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.rd_req = 0; bus.rd_addr = 0;

    tbl[0]  = '{1'b0, 8'h11, 32'hAAAA_0011};
    tbl[1]  = '{1'b0, 8'h12, 32'hBBBB_0012};
    tbl[2]  = '{1'b1, 8'h11, 32'hAAAA_0011};
    tbl[3]  = '{1'b0, 8'h11, 32'hCCCC_0011};
    tbl[4]  = '{1'b1, 8'h11, 32'hCCCC_0011};
    tbl[5]  = '{1'b1, 8'h12, 32'hBBBB_0012};
    tbl[6]  = '{1'b0, 8'hFF, 32'hDEAD_BEEF};
    tbl[7]  = '{1'b1, 8'hFF, 32'hDEAD_BEEF};
    tbl[8]  = '{1'b0, 8'h00, 32'hFFFF_FFFF};
    tbl[9]  = '{1'b1, 8'h00, 32'hFFFF_FFFF};
    tbl[10] = '{1'b1, 8'h05, 32'h1234_5678};
    tbl[11] = '{1'b1, 8'h00, 32'hFFFF_FFFF};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_wb_ready", bus.wb_ready, 1);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we_n", bus.ram_we_n, 1);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic write then read
    push(8'h05, 32'h1234_5678);
    @(negedge clk);
    chk("t2_wr_en_we", {bus.ram_en, bus.ram_we_n}, 2'b10);
    chk("t2_wr_addr", bus.ram_addr, 8'h05);
    chk("t2_wr_data", bus.ram_wdata, 32'h1234_5678);
    @(posedge clk); #1;
    rd(8'h05, 0, d, lat, lvl);
    chk("t2_rd_data", d, 32'h1234_5678);
    chk("t2_rd_latency", lat, 2);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_rd) begin
        rd(tbl[i].addr, 0, d, lat, lvl);
        chk($sformatf("vec%0d_rd_data", i), d, tbl[i].data);
      end else begin
        push(tbl[i].addr, tbl[i].data);
      end
    end
    drain();

    // hazard: read of a queued address drains older writes first
    wlog.delete();
    bus.rd_req = 1'b1; bus.rd_addr = 8'h80;
    push(8'h01, 32'hA);
    push(8'h10, 32'hB);
    push(8'h02, 32'hC);
    wait_rd_ready();
    rd(8'h10, 0, d, lat, lvl);
    chk("t3_rd_data", d, 32'hB);
    chk("t3_level", lvl, 1);
    chk("t3_latency", lat, 4);
    chk("t3_writes_before", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("t3_wr0_addr", wlog[0].a, 8'h01);
      chk("t3_wr1_addr", wlog[1].a, 8'h10);
    end
    drain();
    chk("t3_total_writes", wlog.size(), 3);
    if (wlog.size() >= 3) chk("t3_wr2_addr", wlog[2].a, 8'h02);

    // full FIFO under continuous reads
    wlog.delete();
    maxlvl = 0; forced = 0; saw_full = 0;
    bus.rd_req = 1'b1; bus.rd_addr = 8'h80;
    fork
      begin
        for (int k = 0; k < 6; k++) push(8'h30 + 8'(k), 32'hC000_0000 + 32'(k));
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (int'(bus.fifo_level) > maxlvl) maxlvl = int'(bus.fifo_level);
          if (!bus.wb_ready) saw_full = 1;
          if (bus.fifo_level == 4 && !bus.rd_ready) begin
            forced++;
            chk("t4_forced_write", {bus.ram_en, bus.ram_we_n}, 2'b10);
          end
        end
      end
    join
    drain();
    chk("t4_max_level", maxlvl, 4);
    chk("t4_saw_not_ready", saw_full, 1);
    chk("t4_forced_seen", forced > 0, 1);
    chk("t4_write_count", wlog.size(), 6);
    for (int k = 0; k < 6 && k < wlog.size(); k++) begin
      chk($sformatf("t4_order%0d", k), wlog[k], {8'h30 + 8'(k), 32'hC000_0000 + 32'(k)});
    end

    // starvation bound under back-to-back reads
    bus.rd_req = 1'b1; bus.rd_addr = 8'h40;
    push(8'h20, 32'h55);
    cyc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.ram_en && !bus.ram_we_n && bus.ram_addr == 8'h20) begin
        cyc = c;
        break;
      end
    end
    chk("t5_starve_cycle_in_9_10", (cyc >= 9) && (cyc <= 10), 1);
    drain();

    // push and pop in the same cycle
    bus.rd_req = 1'b1; bus.rd_addr = 8'h80;
    push(8'h61, 32'h1);
    push(8'h62, 32'h2);
    wait_rd_ready();
    chk("t6_level_pre", bus.fifo_level, 2);
    bus.rd_req = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_addr = 8'h63; bus.wb_data = 32'h3;
    @(negedge clk);
    chk("t6_write_grant", {bus.ram_en, bus.ram_we_n}, 2'b10);
    chk("t6_wb_ready", bus.wb_ready, 1);
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("t6_level_post", bus.fifo_level, 2);
    drain();

    // asynchronous reset while in RD with three queued entries
    bus.rd_req = 1'b1; bus.rd_addr = 8'h80;
    push(8'h71, 32'h71);
    push(8'h72, 32'h72);
    push(8'h73, 32'h73);
    #1;
    chk("t1_pre_rd_ready", bus.rd_ready, 1);
    chk("t1_pre_level", bus.fifo_level, 3);
    #1 rst = 1'b1;
    #1;
    chk("t1_rd_ready", bus.rd_ready, 0);
    chk("t1_ram_en", bus.ram_en, 0);
    chk("t1_ram_we_n", bus.ram_we_n, 1);
    chk("t1_level", bus.fifo_level, 0);
    chk("t1_wb_ready", bus.wb_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("t1_post_level", bus.fifo_level, 0);
    chk("t1_post_ram_en", bus.ram_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
